ps2_cmd_seq: RTL
================

// Module: ps2_cmd_seq
// PURPOSE
//  Host-to-keyboard command sequencer for the PS/2 keyboard controller.
//  Takes a 1- or 2-byte keyboard command (e.g. ED+LED mask, F3+rate), feeds the
//  bytes one at a time to the PS/2 transmit path, and checks the keyboard reply:
//  FA = ACK, FE = resend. Retries, times out, and forwards unrelated rx bytes.
//  Sits between the CPU-side port logic and the PS/2 line engine.
// PARAMETERS
//  ACK_TIMEOUT_CYC  640000  wb_clk_i cycles to wait for FA/FE after a byte (20 ms @ 32 MHz)
//  TIMEOUT_BITS     20      width of timeout counter; 2^TIMEOUT_BITS >= ACK_TIMEOUT_CYC
//  MAX_RETRY        3       resends allowed per byte before error
//  RETRY_BITS       2       width of retry counter
// PORTS
//  wb_clk_i       in   1  system clock
//  wb_rst_i       in   1  synchronous reset, active high
//  cmd_stb_i      in   1  command request; level, sampled only in IDLE
//  cmd_dat_i      in   8  command byte
//  cmd_arg_i      in   8  argument byte
//  cmd_has_arg_i  in   1  1 = send cmd_arg_i after command is ACKed
//  cmd_ack_o      out  1  1-cycle pulse: request latched
//  busy_o         out  1  high from latch until DONE/ERR completes
//  tx_dat_o       out  8  byte to line engine; stable while a byte is in flight
//  tx_stb_o       out  1  1-cycle pulse: start transmitting tx_dat_o
//  tx_done_i      in   1  1-cycle pulse: line engine got keyboard line-level ack
//  tx_err_i       in   1  1-cycle pulse: line engine saw no line-level ack
//  rx_dat_i       in   8  received raw byte
//  rx_stb_i       in   1  1-cycle pulse: rx_dat_i valid
//  fwd_dat_o      out  8  forwarded rx byte (non-reply traffic)
//  fwd_stb_o      out  1  1-cycle pulse: fwd_dat_o valid
//  done_o         out  1  1-cycle pulse: all bytes ACKed
//  err_o          out  1  1-cycle pulse: command abandoned
//  err_code_o     out  2  01 resend limit, 10 timeout, 11 line error limit; held until next accept
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters and latched bytes 0.
//  Reset mid-operation: aborts immediately to IDLE, no done_o/err_o pulse.
//  FSM states:
//   IDLE:     cmd_stb_i=1 -> latch cmd/arg/has_arg, retry=0, byte_sel=CMD,
//             err_code_o<=0, cmd_ack_o=1 next cycle -> SEND.
//   SEND:     tx_dat_o <= selected byte; tx_stb_o=1 for exactly 1 cycle -> WAIT_TX.
//   WAIT_TX:  tx_done_i -> WAIT_ACK with timer cleared.
//             tx_err_i -> RETRY, cause=11.
//   WAIT_ACK: timer increments every cycle.
//             rx FA: if byte_sel=CMD and has_arg -> byte_sel=ARG, retry=0, SEND;
//                    otherwise -> DONE.
//             rx FE -> RETRY, cause=01.
//             rx other -> forward it and keep waiting; timer not cleared.
//             timer == ACK_TIMEOUT_CYC-1 with no rx_stb_i -> ERR, code 10.
//             If rx_stb_i and timeout coincide, rx_stb_i wins.
//   RETRY:    retry==MAX_RETRY -> ERR with code=cause; else retry+1 -> SEND
//             (same byte re-sent).
//   DONE:     done_o=1 for 1 cycle -> IDLE.
//   ERR:      err_o=1 for 1 cycle; err_code_o set -> IDLE.
//  busy_o = (state != IDLE); a new request is not sampled in the DONE/ERR cycle.
//  Latency, IDLE with cmd_stb_i to first tx_stb_o: 2 cycles (IDLE->SEND, pulse in SEND).
//  FA to next-byte tx_stb_o: 2 cycles.
//  Forwarding: in every state except WAIT_ACK, every rx byte is forwarded,
//   including FA/FE (unsolicited). In WAIT_ACK only FA/FE are consumed.
//   fwd_stb_o/fwd_dat_o are registered, 1 cycle after rx_stb_i.
//  tx_done_i/tx_err_i outside WAIT_TX are ignored. Both set in one cycle: tx_err_i wins.
//  Timer saturates; it never wraps. Retry counter is reset per byte.
// TESTING
//  1 ED,arg=02: tx ED, done, rx FA; tx 02, done, rx FA -> two tx_stb_o, one done_o, no err_o
//  2 F4, no arg: rx FE twice then FA -> tx F4 three times; done_o; no err_o
//  3 F4: rx FE x4 -> 4 tx_stb_o total, err_o with err_code_o=01, busy_o low next cycle
//  4 F4: tx_done, no rx for ACK_TIMEOUT_CYC (set 100) -> err_o at cycle 100, code 10;
//    also rx 1C at cycle 50 -> fwd 1C, still waits; rx FA at timer=99 with timeout -> done_o
//  5 tx_err_i x4 -> err code 11; rx 1C/FA while IDLE -> forwarded unchanged, 1-cycle latency
//  6 wb_rst_i during WAIT_ACK -> IDLE, outputs 0, no pulses; new cmd then completes normally

Source files
------------

// File: rtl/ps2_cmd_seq.sv
// Host-to-keyboard command sequencer: sends a 1- or 2-byte command over the PS/2
// transmit path, checks FA/FE replies, retries, times out and forwards other rx traffic.
module ps2_cmd_seq #(
  parameter int ACK_TIMEOUT_CYC = 640000,
  parameter int TIMEOUT_BITS    = 20,
  parameter int MAX_RETRY       = 3,
  parameter int RETRY_BITS      = 2
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       cmd_stb_i,
  input  logic [7:0] cmd_dat_i,
  input  logic [7:0] cmd_arg_i,
  input  logic       cmd_has_arg_i,
  output logic       cmd_ack_o,
  output logic       busy_o,
  output logic [7:0] tx_dat_o,
  output logic       tx_stb_o,
  input  logic       tx_done_i,
  input  logic       tx_err_i,
  input  logic [7:0] rx_dat_i,
  input  logic       rx_stb_i,
  output logic [7:0] fwd_dat_o,
  output logic       fwd_stb_o,
  output logic       done_o,
  output logic       err_o,
  output logic [1:0] err_code_o
);

  localparam logic [7:0] KB_ACK    = 8'hFA;
  localparam logic [7:0] KB_RESEND = 8'hFE;
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_RESEND  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_LINE    = 2'b11;
  localparam logic [TIMEOUT_BITS-1:0] TIMER_LAST = TIMEOUT_BITS'(ACK_TIMEOUT_CYC - 1);
  localparam logic [TIMEOUT_BITS-1:0] TIMER_MAX  = {TIMEOUT_BITS{1'b1}};
  localparam logic [TIMEOUT_BITS-1:0] TIMER_ONE  = TIMEOUT_BITS'(1);
  localparam logic [RETRY_BITS-1:0]   RETRY_LIM  = RETRY_BITS'(MAX_RETRY);
  localparam logic [RETRY_BITS-1:0]   RETRY_ONE  = RETRY_BITS'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEND     = 3'd1,
    S_WAIT_TX  = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_RETRY    = 3'd4,
    S_DONE     = 3'd5,
    S_ERR      = 3'd6
  } state_t;

  state_t                  state_r, next_state_s;
  logic [7:0]              cmd_r, arg_r;
  logic                    has_arg_r;
  logic                    byte_sel_r, byte_sel_s;   // 0 = command byte, 1 = argument byte
  logic [RETRY_BITS-1:0]   retry_r, retry_s;
  logic [1:0]              cause_r, cause_s;
  logic [TIMEOUT_BITS-1:0] timer_r, timer_s;
  logic                    accept_s, consume_s;
  logic [7:0]              tx_byte_s;

  // Next-state, counter and reply-consumption decode
  always_comb begin
    next_state_s = state_r;
    byte_sel_s   = byte_sel_r;
    retry_s      = retry_r;
    cause_s      = cause_r;
    timer_s      = timer_r;
    accept_s     = 1'b0;
    consume_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (cmd_stb_i) begin
          accept_s     = 1'b1;
          byte_sel_s   = 1'b0;
          retry_s      = {RETRY_BITS{1'b0}};
          next_state_s = S_SEND;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_SEND: next_state_s = S_WAIT_TX;
      S_WAIT_TX: begin
        if (tx_err_i) begin
          cause_s      = ERR_LINE;
          next_state_s = S_RETRY;
        end else if (tx_done_i) begin
          timer_s      = {TIMEOUT_BITS{1'b0}};
          next_state_s = S_WAIT_ACK;
        end else begin
          next_state_s = S_WAIT_TX;
        end
      end
      S_WAIT_ACK: begin
        timer_s = (timer_r == TIMER_MAX) ? timer_r : timer_r + TIMER_ONE;
        // A received byte always takes precedence over a coincident timeout
        if (rx_stb_i && (rx_dat_i == KB_ACK)) begin
          consume_s = 1'b1;
          if (!byte_sel_r && has_arg_r) begin
            byte_sel_s   = 1'b1;
            retry_s      = {RETRY_BITS{1'b0}};
            next_state_s = S_SEND;
          end else begin
            next_state_s = S_DONE;
          end
        end else if (rx_stb_i && (rx_dat_i == KB_RESEND)) begin
          consume_s    = 1'b1;
          cause_s      = ERR_RESEND;
          next_state_s = S_RETRY;
        end else if (rx_stb_i) begin
          next_state_s = S_WAIT_ACK;
        end else if (timer_r >= TIMER_LAST) begin
          cause_s      = ERR_TIMEOUT;
          next_state_s = S_ERR;
        end else begin
          next_state_s = S_WAIT_ACK;
        end
      end
      S_RETRY: begin
        if (retry_r == RETRY_LIM) begin
          next_state_s = S_ERR;
        end else begin
          retry_s      = retry_r + RETRY_ONE;
          next_state_s = S_SEND;
        end
      end
      S_DONE:  next_state_s = S_IDLE;
      S_ERR:   next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
    if (accept_s) begin
      tx_byte_s = cmd_dat_i;
    end else if (byte_sel_s) begin
      tx_byte_s = arg_r;
    end else begin
      tx_byte_s = cmd_r;
    end
  end

  // Control state, counters and latched command
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r    <= S_IDLE;
      cmd_r      <= 8'h00;
      arg_r      <= 8'h00;
      has_arg_r  <= 1'b0;
      byte_sel_r <= 1'b0;
      retry_r    <= {RETRY_BITS{1'b0}};
      cause_r    <= ERR_NONE;
      timer_r    <= {TIMEOUT_BITS{1'b0}};
    end else begin
      state_r    <= next_state_s;
      byte_sel_r <= byte_sel_s;
      retry_r    <= retry_s;
      cause_r    <= cause_s;
      timer_r    <= timer_s;
      if (accept_s) begin
        cmd_r     <= cmd_dat_i;
        arg_r     <= cmd_arg_i;
        has_arg_r <= cmd_has_arg_i;
      end
    end
  end

  // Registered outputs, decoded from the state being entered
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cmd_ack_o  <= 1'b0;
      busy_o     <= 1'b0;
      tx_dat_o   <= 8'h00;
      tx_stb_o   <= 1'b0;
      fwd_dat_o  <= 8'h00;
      fwd_stb_o  <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      err_code_o <= ERR_NONE;
    end else begin
      cmd_ack_o <= accept_s;
      busy_o    <= (next_state_s != S_IDLE);
      tx_stb_o  <= (next_state_s == S_SEND);
      done_o    <= (next_state_s == S_DONE);
      err_o     <= (next_state_s == S_ERR);
      fwd_stb_o <= rx_stb_i && !consume_s;
      if (next_state_s == S_SEND) begin
        tx_dat_o <= tx_byte_s;
      end
      if (rx_stb_i && !consume_s) begin
        fwd_dat_o <= rx_dat_i;
      end
      if (accept_s) begin
        err_code_o <= ERR_NONE;
      end else if (next_state_s == S_ERR) begin
        err_code_o <= cause_s;
      end
    end
  end

endmodule
